pll_lock_sequencer: RTL and testbench

//  Sequences the ECP5 EHXPLLL 25->133 MHz clock generator. Pulses PLL RST, waits for LOCK and qualifies it as stable.

---
 rtl/pll_lock_sequencer_pkg.sv | 26 ++
 rtl/pll_lock_sequencer_if.sv | 36 +++
 rtl/pll_lock_sequencer_lock_sync.sv | 21 ++
 rtl/pll_lock_sequencer.sv | 130 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// State encodings and sizing helpers for the ECP5 PLL lock sequencer.
package pll_seq_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_RST_ASSERT = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT_LOCK  = 3'd1;
  localparam logic [ST_W-1:0] ST_STABLE     = 3'd2;
  localparam logic [ST_W-1:0] ST_RUN        = 3'd3;
  localparam logic [ST_W-1:0] ST_FAIL       = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_RST_ASSERT = ST_RST_ASSERT,
    S_WAIT_LOCK  = ST_WAIT_LOCK,
    S_STABLE     = ST_STABLE,
    S_RUN        = ST_RUN,
    S_FAIL       = ST_FAIL
  } state_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL sequencer and the board side.
// PLL_LOSS_COUNT_EN adds the loss_cnt status field.
interface pll_lock_sequencer_if;
  import pll_seq_pkg::*;

  logic            restart;
  logic            pll_lock;
  logic            pll_rst;
  logic            sys_rst;
  logic            locked;
  logic            fail;
  logic [ST_W-1:0] state;
  logic [2:0]      retry_cnt;
`ifdef PLL_LOSS_COUNT_EN
  logic [7:0]      loss_cnt;
`endif

  modport master (
    input  restart, pll_lock,
    output pll_rst, sys_rst, locked, fail,
    output state, retry_cnt
`ifdef PLL_LOSS_COUNT_EN
    , output loss_cnt
`endif
  );

  modport slave (
    output restart, pll_lock,
    input  pll_rst, sys_rst, locked, fail,
    input  state, retry_cnt
`ifdef PLL_LOSS_COUNT_EN
    , input loss_cnt
`endif
  );

endinterface

// File: rtl/pll_lock_sequencer_lock_sync.sv
// Two-flop synchronizer bringing PLL LOCK into the reference clock domain.
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer holding sys_rst until lock is stable.
// PLL_LOSS_COUNT_EN adds a saturating lock-loss counter.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input logic                 clki,
  input logic                 rst,
  pll_lock_sequencer_if.master bus
);

  localparam int TW =
    $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [TW-1:0] T_RST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STAB = TW'(STABLE_CYCLES - 1);
  localparam logic [2:0]    R_MAX  = 3'(MAX_RETRIES);

  logic          lock_s;
  state_t        st;
  state_t        nxt;
  logic [TW-1:0] timer;
  logic [2:0]    retry;
  logic [2:0]    retry_nxt;
  logic          lost;
  logic          pll_rst_q;
  logic          sys_rst_q;
  logic          locked_q;
  logic          fail_q;

  lock_sync u_sync (
    .clk (clki),
    .rst (rst),
    .d   (bus.pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    nxt       = st;
    retry_nxt = retry;
    lost      = 1'b0;
    if (bus.restart) begin
      nxt       = S_RST_ASSERT;
      retry_nxt = '0;
    end else begin
      case (st)
        S_RST_ASSERT: begin
          if (timer == T_RST) nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            nxt = S_STABLE;
          end else if (timer == T_LOCK) begin
            retry_nxt = (retry == 3'd7) ? retry : retry + 3'd1;
            nxt = (retry_nxt == R_MAX) ? S_FAIL : S_RST_ASSERT;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            nxt = S_WAIT_LOCK;
          end else if (timer == T_STAB) begin
            nxt       = S_RUN;
            retry_nxt = '0;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            nxt  = S_RST_ASSERT;
            lost = 1'b1;
          end
        end
        S_FAIL: nxt = S_FAIL;
        default: nxt = S_RST_ASSERT;
      endcase
    end
  end

  // timer restarts on every entry, including restart into RST_ASSERT
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      st        <= S_RST_ASSERT;
      timer     <= '0;
      retry     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      st    <= nxt;
      retry <= retry_nxt;
      if (nxt != st || bus.restart || st == S_RUN || st == S_FAIL)
        timer <= '0;
      else
        timer <= timer + TW'(1);
      pll_rst_q <= (nxt == S_RST_ASSERT) || (nxt == S_FAIL);
      sys_rst_q <= (nxt != S_RUN);
      locked_q  <= (nxt == S_RUN);
      fail_q    <= (nxt == S_FAIL);
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clki or posedge rst) begin
    if (rst)
      loss_q <= '0;
    else if (lost && loss_q != 8'hff)
      loss_q <= loss_q + 8'd1;
  end

  assign bus.loss_cnt = loss_q;
`else
  logic unused_lost;
  assign unused_lost = lost;
`endif

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;
  assign bus.state     = st;
  assign bus.retry_cnt = retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer (LOCK_TIMEOUT shortened to 100).
module tb_pll_lock_sequencer;

  logic clki = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES    (16),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (1024),
    .MAX_RETRIES   (4)
  ) dut (
    .clki (clki),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clki = ~clki;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  function automatic logic sig(int sel);
    case (sel)
      0:       return bus.pll_rst;
      1:       return bus.locked;
      default: return bus.sys_rst;
    endcase
  endfunction

  // edges until the selected output reaches val, bounded by lim
  task automatic wait_for(string tag, int sel, logic val,
                          int lim, int exp);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (sig(sel) !== val && n < lim);
    chk(tag, n, exp);
  endtask

  initial begin
    rst          = 1'b1;
    bus.restart  = 1'b0;
    bus.pll_lock = 1'b1;
    tick(3);
    chk("rst_pll_rst", bus.pll_rst, 1);
    chk("rst_sys_rst", bus.sys_rst, 1);
    chk("rst_locked", bus.locked, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_retry", bus.retry_cnt, 0);

    rst = 1'b0;
    wait_for("t1_pll_rst_len", 0, 1'b0, 100, 16);
    wait_for("t1_to_locked", 1, 1'b1, 3000, 1025);
    chk("t1_sys_rst", bus.sys_rst, 0);
    chk("t1_state", bus.state, 3);
    chk("t1_retry", bus.retry_cnt, 0);

    bus.pll_lock = 1'b0;
    tick(1);
    bus.pll_lock = 1'b1;
    wait_for("t2_sys_rst_lat", 2, 1'b1, 10, 2);
    chk("t2_locked", bus.locked, 0);
    chk("t2_pll_rst", bus.pll_rst, 1);
    chk("t2_state", bus.state, 0);
    wait_for("t2_pll_rst_len", 0, 1'b0, 100, 16);
    wait_for("t2_to_locked", 1, 1'b1, 3000, 1025);

    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    chk("t5_run_state", bus.state, 0);
    chk("t5_run_sys_rst", bus.sys_rst, 1);
    chk("t5_run_locked", bus.locked, 0);
    chk("t5_run_retry", bus.retry_cnt, 0);
    wait_for("t4_pll_rst_len", 0, 1'b0, 100, 16);
    tick(501);
    chk("t4_stable", bus.state, 2);
    bus.pll_lock = 1'b0;
    tick(1);
    bus.pll_lock = 1'b1;
    tick(2);
    chk("t4_back_wait", bus.state, 1);
    chk("t4_retry", bus.retry_cnt, 0);
    chk("t4_sys_rst", bus.sys_rst, 1);
    wait_for("t4_fresh_stable", 1, 1'b1, 3000, 1025);

    bus.pll_lock = 1'b0;
    wait_for("t3_loss_lat", 0, 1'b1, 10, 3);
    chk("t3_locked", bus.locked, 0);
    for (int i = 1; i <= 4; i++) begin
      wait_for($sformatf("t3_rst_len%0d", i), 0, 1'b0, 100, 16);
      wait_for($sformatf("t3_wait_len%0d", i), 0, 1'b1, 300, 100);
      chk($sformatf("t3_retry%0d", i), bus.retry_cnt, i);
      chk($sformatf("t3_fail%0d", i), bus.fail, (i == 4) ? 1 : 0);
    end
    tick(50);
    chk("t3_fail_hold", bus.fail, 1);
    chk("t3_pll_rst_hold", bus.pll_rst, 1);
    chk("t3_state_fail", bus.state, 4);
    chk("t3_retry_hold", bus.retry_cnt, 4);

    bus.pll_lock = 1'b1;
    tick(5);
    chk("t5_fail_stays", bus.state, 4);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    chk("t5_fail_state", bus.state, 0);
    chk("t5_fail_retry", bus.retry_cnt, 0);
    chk("t5_fail_fail", bus.fail, 0);
    chk("t5_fail_sys_rst", bus.sys_rst, 1);
    wait_for("t5_pll_rst_len", 0, 1'b0, 100, 16);
    wait_for("t5_to_locked", 1, 1'b1, 3000, 1025);

`ifdef PLL_LOSS_COUNT_EN
    chk("t6_loss2", bus.loss_cnt, 2);
    bus.pll_lock = 1'b0;
    tick(1);
    bus.pll_lock = 1'b1;
    wait_for("t6_sys_rst_lat", 2, 1'b1, 10, 2);
    chk("t6_loss3", bus.loss_cnt, 3);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    chk("t6_restart_keeps", bus.loss_cnt, 3);
    wait_for("t6_pll_rst_len", 0, 1'b0, 100, 16);
    wait_for("t6_to_locked", 1, 1'b1, 3000, 1025);
`endif

    tick(20);
    chk("async_pre_locked", bus.locked, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_pll_rst", bus.pll_rst, 1);
    chk("async_sys_rst", bus.sys_rst, 1);
    chk("async_locked", bus.locked, 0);
    chk("async_state", bus.state, 0);
`ifdef PLL_LOSS_COUNT_EN
    chk("t6_rst_clears", bus.loss_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
